// File: rtl/barrel_shifter_pipe.sv
// Pipelined, parametrised barrel shifter (SLL/SRL/SRA/ROL) with a valid/ready handshake on both sides.
// Define BARREL_SHIFTER_CARRY_EN to add the out_carry port (last bit shifted out).
module barrel_shifter_pipe #(
  parameter int  WIDTH          = 16,
  parameter int  STAGES_PER_REG = 2,
  localparam int CNT_W          = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BARREL_SHIFTER_CARRY_EN
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int SPR_SAFE  = (STAGES_PER_REG < 1) ? 1 : STAGES_PER_REG;
  localparam int NUM_SLOTS = (CNT_W + SPR_SAFE - 1) / SPR_SAFE;

  if ((WIDTH < 2) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("barrel_shifter_pipe: WIDTH must be a power of two in 2..64");
  end
  if ((STAGES_PER_REG < 1) || (STAGES_PER_REG > CNT_W)) begin : g_bad_spr
    $error("barrel_shifter_pipe: STAGES_PER_REG must be in 1..log2(WIDTH)");
  end

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // One pipeline slot; sign is the operand MSB captured at the input for SRA fill.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    op_e              op;
    logic             sign;
`ifdef BARREL_SHIFTER_CARRY_EN
    logic             carry;
`endif
  } slot_t;

  // Applies log-stage k (shift by 2^k) when the matching count bit is set.
  function automatic slot_t shift_stage(input slot_t s, input int k);
    slot_t            r;
    int               amt;
    logic [CNT_W-1:0] cnt_sh;
`ifdef BARREL_SHIFTER_CARRY_EN
    logic [WIDTH-1:0] out_bits;
`endif
    r      = s;
    amt    = 1 << k;
    cnt_sh = s.cnt >> k;
    if (cnt_sh[0]) begin
      unique case (s.op)
        OP_SLL: r.data = s.data << amt;
        OP_SRL: r.data = s.data >> amt;
        OP_SRA: r.data = (s.data >> amt) | (s.sign ? ~({WIDTH{1'b1}} >> amt) : '0);
        OP_ROL: r.data = (s.data << amt) | (s.data >> (WIDTH - amt));
        default: r.data = s.data;
      endcase
`ifdef BARREL_SHIFTER_CARRY_EN
      // The lowest (left shifts) or highest (right shifts) bit leaving this stage is the newest carry.
      if ((s.op == OP_SLL) || (s.op == OP_ROL)) out_bits = s.data >> (WIDTH - amt);
      else                                      out_bits = s.data >> (amt - 1);
      r.carry = out_bits[0];
`endif
    end
    return r;
  endfunction

  slot_t in_slot;
  slot_t slot_d [NUM_SLOTS];
  slot_t slot_q [NUM_SLOTS];
  logic  advance;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    in_slot       = '0;
    in_slot.valid = in_valid;
    in_slot.data  = in_data;
    in_slot.cnt   = in_cnt;
    in_slot.op    = op_e'(in_op);
    in_slot.sign  = in_data[WIDTH-1];
  end

  always_comb begin
    slot_d[0] = in_slot;
    for (int s = 1; s < NUM_SLOTS; s++) begin
      slot_d[s] = slot_q[s-1];
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int k = 0; k < CNT_W; k++) begin
        if ((k / SPR_SAFE) == s) slot_d[s] = shift_stage(slot_d[s], k);
      end
    end
  end

  // Single global stall: the whole pipe moves only when the output slot is empty or draining.
  assign advance  = !slot_q[NUM_SLOTS-1].valid || out_ready;
  assign in_ready = advance;

  // NOTE: sequential state uses non-blocking assignments so all slots sample their predecessors' old values.
  // NOTE: data/cnt/op registers are reset as well, because out_data must read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= '0;
    end else if (advance) begin
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= slot_d[s];
    end
  end

  assign out_valid = slot_q[NUM_SLOTS-1].valid;
  assign out_data  = slot_q[NUM_SLOTS-1].data;
`ifdef BARREL_SHIFTER_CARRY_EN
  assign out_carry = slot_q[NUM_SLOTS-1].carry;
`endif

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter for the CPU datapath and the coprocessor datapath.
- Generalises the fixed 16-bit combinational left-logical shifter in three ways:
  - width is a parameter;
  - four shift modes are supported;
  - pipeline registers are inserted between groups of log-stages, with a valid/ready handshake on both sides.
- Sits between the register-read stage and the ALU result mux; also serves as the shift unit of the multi-cycle coprocessor.

Parameters:
- WIDTH, 16: data width; power of two, 2..64. Derived localparam CNT_W = log2(WIDTH).
- STAGES_PER_REG, 2: number of log-shift mux stages between pipeline registers; 1..CNT_W.

Ports:
- clk  in  1: clock; all state on rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: in_data/in_cnt/in_op are valid this cycle.
- in_ready  out  1: shifter accepts an operand this cycle.
- in_data  in  WIDTH: operand.
- in_cnt  in  CNT_W: shift amount, 0..WIDTH-1.
- in_op  in  2: shift mode.
  - 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  out  1: out_data valid.
- out_ready  in  1: consumer accepts result.
- out_data  out  WIDTH: shifted result.

Behaviour:
- Reset (async assert, release sync to clk): all stage valid bits 0, all data/cnt/op pipeline registers 0, out_valid=0, out_data=0.
- Shift decomposition:
  - Stage k (k=0..CNT_W-1) shifts by 2^k when cnt[k]=1, in ascending k.
  - SLL: zero fill from LSB.
  - SRL: zero fill from MSB.
  - SRA: fill with in_data[WIDTH-1], captured at input and carried down the pipe.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- Pipeline:
  - Number of register slots L = ceil(CNT_W / STAGES_PER_REG); the last slot drives out_data/out_valid.
  - WIDTH=16, STAGES_PER_REG=2 gives L=2.
  - Each slot carries valid, data, remaining cnt bits, op and sign bit.
- Handshake:
  - Global advance = !out_valid || out_ready. in_ready = advance (combinational).
  - On advance, every slot loads from its predecessor; slot 0 loads in_valid and the operand.
  - Without advance, all slots hold.
  - Latency is L cycles from accepted input to out_valid with no stall.
  - Throughput is 1/cycle.
  - Bubbles are not compressed (global stall).
- Data stability: out_data and out_valid are stable while out_valid=1 && out_ready=0.
- Simultaneous events: a new accept and a result drain in the same cycle are both legal.
- in_valid=0 while advancing: a bubble (valid=0) enters slot 0; data registers of invalid slots may update but are don't-care.
- cnt=0: out_data equals in_data for every op.
- Ordering: results leave in acceptance order; none are dropped or duplicated.
- Reset mid-operation: all in-flight operands are discarded; out_valid=0 immediately on rst assertion.
- Illegal parameters (WIDTH not a power of two, STAGES_PER_REG out of range): elaboration error via generate-time check.

Optional Feature:
- Macro BARREL_SHIFTER_CARRY_EN.
- When defined, adds output port out_carry (out, 1, valid with out_data): the last bit shifted out.
  - SLL/ROL: bit in_data[WIDTH-cnt].
  - SRL/SRA: bit in_data[cnt-1].
  - 0 when cnt=0.
  - Piped alongside data; resets to 0.
- When undefined, the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- Basic SLL: WIDTH=16, out_ready=1; SLL 0x0001 cnt=4 at cycle 0 -> out_valid=1, out_data=0x0010 at cycle 2 only.
- SRA and SRL: SRA 0x8000 cnt=15 -> 0xFFFF; SRL 0x8000 cnt=15 -> 0x0001; SRA 0x7FF0 cnt=4 -> 0x07FF.
- Rotate and pass-through: ROL 0x8001 cnt=1 -> 0x0003; ROL 0xABCD cnt=0 -> 0xABCD; SLL 0xFFFF cnt=0 -> 0xFFFF.
- Back-pressure:
  - Issue 0x0001 with cnt=1,2,3 on consecutive cycles; hold out_ready=0 from cycle 2 to cycle 6.
  - Required: in_ready=0 while the pipe is full; out_data held at 0x0002.
  - On release, outputs 0x0002, 0x0004, 0x0008 on consecutive cycles; no loss or duplicate.
- Reset mid-flight: two operands in flight, assert rst for 1 cycle -> out_valid=0 immediately; no stale result ever emerges after release.
- With BARREL_SHIFTER_CARRY_EN: SLL 0x8000 cnt=1 -> out_data=0x0000, out_carry=1; SRL 0x0002 cnt=2 -> out_data=0x0000, out_carry=1; cnt=0 -> out_carry=0.
